// File: rtl/pu_accum_pkg.sv
// pu_accum_pkg: attribute bit indices and width helpers shared by the accumulator bank
package pu_accum_pkg;

   localparam int SIGN     = 0;
   localparam int OVERFLOW = 1;

   // Two's complement limit for a w-bit value: neg=0 -> max, neg=1 -> min (low w bits valid)
   function automatic logic [63:0] sat_lim(input int w, input logic neg);
      logic [63:0] m;
      m = 64'(1) << (w - 1);
      return neg ? m : m - 64'(1);
   endfunction

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/pu_accum_bank_if.sv
// pu_accum_bank_if: processor-bus control, load and read lines of the accumulator bank
interface pu_accum_bank_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ATTR_WIDTH = 4,
   parameter int SEL_WIDTH  = 2
);
   logic                  signal_load;
   logic                  signal_init;
   logic                  signal_neg;
   logic [SEL_WIDTH-1:0]  signal_sel;
   logic [DATA_WIDTH-1:0] data_in;
   logic [ATTR_WIDTH-1:0] attr_in;
   logic                  signal_oe;
   logic [SEL_WIDTH-1:0]  signal_oe_sel;
   logic [DATA_WIDTH-1:0] data_out;
   logic [ATTR_WIDTH-1:0] attr_out;

   modport master (
      output signal_load, signal_init, signal_neg, signal_sel, data_in, attr_in,
             signal_oe, signal_oe_sel,
      input  data_out, attr_out
   );

   modport slave (
      input  signal_load, signal_init, signal_neg, signal_sel, data_in, attr_in,
             signal_oe, signal_oe_sel,
      output data_out, attr_out
   );
endinterface

// File: rtl/pu_accum_bank_alu.sv
// pu_accum_bank_alu: stage-2 signed add with overflow detection and optional clamping
module pu_accum_bank_alu
   import pu_accum_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int SATURATE   = 0
) (
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] ext,
   input  logic                  neg_ovf,
   output logic [DATA_WIDTH:0]   s,
   output logic                  arith_ovf,
   output logic [DATA_WIDTH-1:0] res
);
   localparam int DW = DATA_WIDTH;
   localparam logic [63:0] MAX_W = sat_lim(DW, 1'b0);
   localparam logic [63:0] MIN_W = sat_lim(DW, 1'b1);
   localparam logic [DW-1:0] MAX = MAX_W[DW-1:0];
   localparam logic [DW-1:0] MIN = MIN_W[DW-1:0];

   logic [DW-1:0] e;

   // negated most-negative operand becomes +max when clamping; exact sum decides overflow
   always_comb begin
      e = (SATURATE != 0 && neg_ovf) ? MAX : ext;
      s = {a[DW-1], a} + {e[DW-1], e};
      arith_ovf = (s[DW] ^ s[DW-1]) | neg_ovf;
      res = (SATURATE != 0 && arith_ovf) ? (s[DW] ? MIN : MAX) : s[DW-1:0];
   end
endmodule

// File: rtl/pu_accum_bank.sv
// pu_accum_bank: multi-channel signed accumulator bank with pipelined load and bypassed read
module pu_accum_bank
   import pu_accum_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ATTR_WIDTH = 4,
   parameter int SIGN       = pu_accum_pkg::SIGN,
   parameter int OVERFLOW   = pu_accum_pkg::OVERFLOW,
   parameter int CHANNELS   = 4,
   parameter int SEL_WIDTH  = 2,
   parameter int SATURATE   = 0
) (
   input logic             clk,
   input logic             rst,
   pu_accum_bank_if.slave  bus
);
   localparam int DW = DATA_WIDTH;
   localparam int IW = (clog2(CHANNELS) > 1) ? clog2(CHANNELS) : 1;

   if (SEL_WIDTH < IW) begin : g_sel_check
      $error("SEL_WIDTH too narrow for CHANNELS");
   end

   logic                  v1_q, v1_d, init1_q, init1_d, novf1_q, novf1_d, aovf1_q, aovf1_d;
   logic [SEL_WIDTH-1:0]  ch1_q, ch1_d;
   logic [DW-1:0]         ext1_q, ext1_d;
   logic [DW-1:0]         acc_q [CHANNELS];
   logic [DW-1:0]         acc_d [CHANNELS];
   logic [CHANNELS-1:0]   sgn_q, sgn_d, ovf_q, ovf_d;
   logic [DW-1:0]         data_out_q, data_out_d;
   logic [ATTR_WIDTH-1:0] attr_out_q, attr_out_d;
   logic [IW-1:0]         wi, ri;
   logic                  wr, rd, arith_ovf;
   logic [DW-1:0]         a, res;
   logic [DW:0]           s;
   logic [1:0]            unused_bits;

   assign unused_bits = {^bus.attr_in, ^s[DW-1:0]};

   // stage-1 capture of the load and selection of the stage-2 addend
   always_comb begin
      v1_d = bus.signal_load;
      ch1_d = bus.signal_sel;
      init1_d = bus.signal_init;
      ext1_d = bus.signal_neg ? -bus.data_in : bus.data_in;
      novf1_d = bus.signal_neg && bus.data_in == {1'b1, {(DW-1){1'b0}}};
      aovf1_d = bus.attr_in[OVERFLOW];
      wi = ch1_q[IW-1:0];
      ri = bus.signal_oe_sel[IW-1:0];
      wr = v1_q && int'(ch1_q) < CHANNELS;
      rd = bus.signal_oe && int'(bus.signal_oe_sel) < CHANNELS;
      a = init1_q ? '0 : acc_q[wi];
   end

   pu_accum_bank_alu #(.DATA_WIDTH(DW), .SATURATE(SATURATE)) u_alu (
      .a         (a),
      .ext       (ext1_q),
      .neg_ovf   (novf1_q),
      .s         (s),
      .arith_ovf (arith_ovf),
      .res       (res)
   );

   // stage-2 writeback; the read port sees the post-write state so same-cycle writes bypass
   always_comb begin
      acc_d = acc_q;
      sgn_d = sgn_q;
      ovf_d = ovf_q;
      if (wr) begin
         acc_d[wi] = res;
         sgn_d[wi] = s[DW];
         ovf_d[wi] = (!init1_q && ovf_q[wi]) | aovf1_q | arith_ovf;
      end
      data_out_d = rd ? acc_d[ri] : '0;
      attr_out_d = '0;
      attr_out_d[SIGN] = rd & sgn_d[ri];
      attr_out_d[OVERFLOW] = rd & ovf_d[ri];
   end

   // state registers; reset drops any load still in stage 1
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v1_q <= 1'b0;
         ch1_q <= '0;
         init1_q <= 1'b0;
         ext1_q <= '0;
         novf1_q <= 1'b0;
         aovf1_q <= 1'b0;
         acc_q <= '{default: '0};
         sgn_q <= '0;
         ovf_q <= '0;
         data_out_q <= '0;
         attr_out_q <= '0;
      end else begin
         v1_q <= v1_d;
         ch1_q <= ch1_d;
         init1_q <= init1_d;
         ext1_q <= ext1_d;
         novf1_q <= novf1_d;
         aovf1_q <= aovf1_d;
         acc_q <= acc_d;
         sgn_q <= sgn_d;
         ovf_q <= ovf_d;
         data_out_q <= data_out_d;
         attr_out_q <= attr_out_d;
      end
   end

   assign bus.data_out = data_out_q;
   assign bus.attr_out = attr_out_q;
endmodule

// File: tb/tb_pu_accum_bank.sv
// tb_pu_accum_bank: wrap and saturating banks driven in lockstep against a queued reference model
module tb_pu_accum_bank;
   import pu_accum_pkg::*;

   typedef struct packed {
      logic       ld, in, ng;
      logic [2:0] sel;
      logic [7:0] d;
      logic       ao, oe;
      logic [2:0] osel;
   } row_t;

   typedef struct packed {
      logic [7:0] d0;
      logic [3:0] a0;
      logic [7:0] d1;
      logic [3:0] a1;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad = 0;

   logic [7:0] m_acc [2][4];
   logic       m_sgn [2][4];
   logic       m_ovf [2][4];
   row_t       pend;
   exp_t       sbq[$];

   pu_accum_bank_if #(.DATA_WIDTH(8), .ATTR_WIDTH(4), .SEL_WIDTH(3)) ifw ();
   pu_accum_bank_if #(.DATA_WIDTH(8), .ATTR_WIDTH(4), .SEL_WIDTH(3)) ifs ();

   assign ifs.signal_load   = ifw.signal_load;
   assign ifs.signal_init   = ifw.signal_init;
   assign ifs.signal_neg    = ifw.signal_neg;
   assign ifs.signal_sel    = ifw.signal_sel;
   assign ifs.data_in       = ifw.data_in;
   assign ifs.attr_in       = ifw.attr_in;
   assign ifs.signal_oe     = ifw.signal_oe;
   assign ifs.signal_oe_sel = ifw.signal_oe_sel;

   pu_accum_bank #(.DATA_WIDTH(8), .ATTR_WIDTH(4), .CHANNELS(4), .SEL_WIDTH(3), .SATURATE(0))
      u_wrap (.clk(clk), .rst(rst), .bus(ifw));
   pu_accum_bank #(.DATA_WIDTH(8), .ATTR_WIDTH(4), .CHANNELS(4), .SEL_WIDTH(3), .SATURATE(1))
      u_sat (.clk(clk), .rst(rst), .bus(ifs));

   always #5 clk = ~clk;

   function automatic row_t rw(input int ld, input int in, input int ng, input int sel,
                               input int d, input int ao, input int oe, input int osel);
      row_t r;
      r.ld = ld[0];
      r.in = in[0];
      r.ng = ng[0];
      r.sel = 3'(sel);
      r.d = 8'(d);
      r.ao = ao[0];
      r.oe = oe[0];
      r.osel = 3'(osel);
      return r;
   endfunction

   task automatic model_clear();
      for (int m = 0; m < 2; m++)
         for (int c = 0; c < 4; c++) begin
            m_acc[m][c] = 8'h00;
            m_sgn[m][c] = 1'b0;
            m_ovf[m][c] = 1'b0;
         end
      pend = '0;
   endtask

   // applies the load captured last cycle, queues the expected read, drives this cycle, waits one edge
   task automatic step(input row_t r);
      exp_t e;
      int   c;
      c = int'(pend.sel);
      if (pend.ld && c < 4) begin
         for (int m = 0; m < 2; m++) begin
            int x, s;
            bit no, of;
            x = int'($signed(pend.d));
            no = pend.ng && pend.d == 8'h80;
            if (pend.ng) x = -x;
            if (no) x = (m == 1) ? 127 : -128;
            s = (pend.in ? 0 : int'($signed(m_acc[m][c]))) + x;
            of = s > 127 || s < -128 || no;
            m_acc[m][c] = (m == 1 && of) ? (s < 0 ? 8'h80 : 8'h7F) : 8'(s);
            m_sgn[m][c] = s < 0;
            m_ovf[m][c] = (!pend.in && m_ovf[m][c]) || pend.ao || of;
         end
      end
      e = '0;
      if (r.oe && r.osel < 4) begin
         e.d0 = m_acc[0][r.osel[1:0]];
         e.a0 = {2'b00, m_ovf[0][r.osel[1:0]], m_sgn[0][r.osel[1:0]]};
         e.d1 = m_acc[1][r.osel[1:0]];
         e.a1 = {2'b00, m_ovf[1][r.osel[1:0]], m_sgn[1][r.osel[1:0]]};
      end
      sbq.push_back(e);
      pend = r;
      ifw.signal_load = r.ld;
      ifw.signal_init = r.in;
      ifw.signal_neg = r.ng;
      ifw.signal_sel = r.sel;
      ifw.data_in = r.d;
      ifw.attr_in = {2'b00, r.ao, 1'b0};
      ifw.signal_oe = r.oe;
      ifw.signal_oe_sel = r.osel;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      step(rw(0, 0, 0, 0, 0, 0, 0, 0));
      void'(sbq.pop_front());
      @(posedge clk);
      #1;
      total += 2;
      if ({ifw.data_out, ifw.attr_out} !== 12'h000) begin
         bad++;
         $display("FAIL reset wrap: got %h/%h want 00/0", ifw.data_out, ifw.attr_out);
      end
      if ({ifs.data_out, ifs.attr_out} !== 12'h000) begin
         bad++;
         $display("FAIL reset sat: got %h/%h want 00/0", ifs.data_out, ifs.attr_out);
      end
      @(negedge clk);
      rst = 1'b1;
      model_clear();
   endtask

   task automatic test_interleave();
      row_t rows [8] = '{rw(1,1,0,1,10,0,0,0), rw(1,1,0,2,'hFC,0,0,0), rw(1,0,0,1,20,0,0,0),
                         rw(1,0,0,2,1,0,0,0), rw(0,0,0,0,0,0,1,1), rw(0,0,0,0,0,0,1,2),
                         rw(0,0,0,0,0,0,1,0), rw(0,0,0,0,0,0,1,3)};
      foreach (rows[i]) begin
         exp_t e;
         step(rows[i]);
         e = sbq.pop_front();
         total += 2;
         if ({ifw.data_out, ifw.attr_out} !== {e.d0, e.a0}) begin
            bad++;
            $display("FAIL interleave[%0d] wrap: got %h/%h want %h/%h", i, ifw.data_out, ifw.attr_out, e.d0, e.a0);
         end
         if ({ifs.data_out, ifs.attr_out} !== {e.d1, e.a1}) begin
            bad++;
            $display("FAIL interleave[%0d] sat: got %h/%h want %h/%h", i, ifs.data_out, ifs.attr_out, e.d1, e.a1);
         end
         if (i == 5) begin
            total++;
            if ({ifw.data_out, ifw.attr_out} !== 12'hFD1) begin
               bad++;
               $display("FAIL interleave ch2 plan: got %h/%h want fd/1", ifw.data_out, ifw.attr_out);
            end
         end
      end
   endtask

   task automatic test_basic();
      row_t rows [5] = '{rw(1,1,0,0,5,0,0,0), rw(1,0,1,0,3,0,0,0), rw(0,0,0,0,0,0,0,0),
                         rw(0,0,0,0,0,0,1,0), rw(0,0,0,0,0,0,0,0)};
      foreach (rows[i]) begin
         exp_t e;
         step(rows[i]);
         e = sbq.pop_front();
         total += 2;
         if ({ifw.data_out, ifw.attr_out} !== {e.d0, e.a0}) begin
            bad++;
            $display("FAIL basic[%0d] wrap: got %h/%h want %h/%h", i, ifw.data_out, ifw.attr_out, e.d0, e.a0);
         end
         if ({ifs.data_out, ifs.attr_out} !== {e.d1, e.a1}) begin
            bad++;
            $display("FAIL basic[%0d] sat: got %h/%h want %h/%h", i, ifs.data_out, ifs.attr_out, e.d1, e.a1);
         end
         if (i == 3) begin
            total++;
            if ({ifw.data_out, ifw.attr_out} !== 12'h020) begin
               bad++;
               $display("FAIL basic plan: got %h/%h want 02/0", ifw.data_out, ifw.attr_out);
            end
         end
      end
   endtask

   task automatic test_overflow();
      row_t rows [9] = '{rw(1,1,0,0,100,0,0,0), rw(1,0,0,0,100,0,0,0), rw(0,0,0,0,0,0,1,0),
                         rw(1,1,0,0,1,0,0,0), rw(0,0,0,0,0,0,1,0), rw(1,0,0,0,0,1,0,0),
                         rw(0,0,0,0,0,0,1,0), rw(1,1,1,3,'h80,0,0,0), rw(0,0,0,0,0,0,1,3)};
      foreach (rows[i]) begin
         exp_t e;
         step(rows[i]);
         e = sbq.pop_front();
         total += 2;
         if ({ifw.data_out, ifw.attr_out} !== {e.d0, e.a0}) begin
            bad++;
            $display("FAIL overflow[%0d] wrap: got %h/%h want %h/%h", i, ifw.data_out, ifw.attr_out, e.d0, e.a0);
         end
         if ({ifs.data_out, ifs.attr_out} !== {e.d1, e.a1}) begin
            bad++;
            $display("FAIL overflow[%0d] sat: got %h/%h want %h/%h", i, ifs.data_out, ifs.attr_out, e.d1, e.a1);
         end
         if (i == 2 || i == 8) begin
            total += 2;
            if (ifw.data_out !== (i == 2 ? 8'hC8 : 8'h80) || ifw.attr_out[OVERFLOW] !== 1'b1) begin
               bad++;
               $display("FAIL overflow plan[%0d] wrap: got %h/%h", i, ifw.data_out, ifw.attr_out);
            end
            if (ifs.data_out !== 8'h7F || ifs.attr_out[OVERFLOW] !== 1'b1) begin
               bad++;
               $display("FAIL overflow plan[%0d] sat: got %h/%h want 7f/ovf", i, ifs.data_out, ifs.attr_out);
            end
         end
      end
   endtask

   task automatic test_bypass();
      row_t rows [11] = '{rw(1,1,0,2,7,0,0,0), rw(0,0,0,0,0,0,1,2), rw(0,0,0,0,0,0,0,2),
                          rw(0,0,0,0,0,0,1,5), rw(1,1,0,6,9,0,0,0), rw(0,0,0,0,0,0,1,2),
                          rw(1,1,0,1,1,0,0,0), rw(1,0,0,1,1,0,1,1), rw(1,0,0,1,1,0,1,1),
                          rw(1,1,0,0,'h11,0,1,1), rw(0,0,0,0,0,0,1,2)};
      foreach (rows[i]) begin
         exp_t e;
         step(rows[i]);
         e = sbq.pop_front();
         total += 2;
         if ({ifw.data_out, ifw.attr_out} !== {e.d0, e.a0}) begin
            bad++;
            $display("FAIL bypass[%0d] wrap: got %h/%h want %h/%h", i, ifw.data_out, ifw.attr_out, e.d0, e.a0);
         end
         if ({ifs.data_out, ifs.attr_out} !== {e.d1, e.a1}) begin
            bad++;
            $display("FAIL bypass[%0d] sat: got %h/%h want %h/%h", i, ifs.data_out, ifs.attr_out, e.d1, e.a1);
         end
         if (i == 1 || i == 9) begin
            total++;
            if (ifw.data_out !== (i == 1 ? 8'h07 : 8'h03)) begin
               bad++;
               $display("FAIL bypass plan[%0d]: got %h", i, ifw.data_out);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      row_t rows [4] = '{rw(0,0,0,0,0,0,1,0), rw(0,0,0,0,0,0,1,1), rw(0,0,0,0,0,0,1,2),
                         rw(0,0,0,0,0,0,1,3)};
      exp_t e;
      step(rw(1,1,0,1,'h55,0,1,2));
      e = sbq.pop_front();
      total++;
      if (ifw.data_out !== e.d0) begin
         bad++;
         $display("FAIL reset_mid pre: got %h want %h", ifw.data_out, e.d0);
      end
      #2 rst = 1'b0;
      #1;
      total += 2;
      if ({ifw.data_out, ifw.attr_out} !== 12'h000) begin
         bad++;
         $display("FAIL reset_mid async wrap: got %h/%h want 00/0", ifw.data_out, ifw.attr_out);
      end
      if ({ifs.data_out, ifs.attr_out} !== 12'h000) begin
         bad++;
         $display("FAIL reset_mid async sat: got %h/%h want 00/0", ifs.data_out, ifs.attr_out);
      end
      @(negedge clk);
      rst = 1'b1;
      model_clear();
      foreach (rows[i]) begin
         step(rows[i]);
         e = sbq.pop_front();
         total += 2;
         if ({ifw.data_out, ifw.attr_out} !== {e.d0, e.a0}) begin
            bad++;
            $display("FAIL reset_mid[%0d] wrap: got %h/%h want %h/%h", i, ifw.data_out, ifw.attr_out, e.d0, e.a0);
         end
         if ({ifs.data_out, ifs.attr_out} !== {e.d1, e.a1}) begin
            bad++;
            $display("FAIL reset_mid[%0d] sat: got %h/%h want %h/%h", i, ifs.data_out, ifs.attr_out, e.d1, e.a1);
         end
      end
   endtask

   initial begin
      model_clear();
      test_reset();
      test_interleave();
      test_basic();
      test_overflow();
      test_bypass();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pu_accum_bank.md
Name: pu_accum_bank

Overview:
- Multi-channel signed accumulator processing unit: CHANNELS independent accumulators share one load port and one read port.
- Optional saturation mode; per-channel sticky overflow flag and a true-sign attribute.
- Sits on the processor bus like other PUs: driven by signal_* control lines, delivers data_out/attr_out under signal_oe.
- Two-stage load pipeline (capture, add) sustains one load per cycle on any channel mix.

Parameters:
- DATA_WIDTH, 8, width of data_in/data_out and of each accumulator (two's complement).
- ATTR_WIDTH, 4, width of attr_in/attr_out.
- SIGN, 0, attr bit index carrying the sign.
- OVERFLOW, 1, attr bit index carrying the overflow flag.
- CHANNELS, 4, number of accumulators (>=1).
- SEL_WIDTH, 2, channel select width (>= max(1, clog2(CHANNELS))).
- SATURATE, 0, 1 = clamp on arithmetic overflow, 0 = wrap.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous reset, active-low
- signal_load  in  1  accept data_in into channel signal_sel this cycle
- signal_init  in  1  with load: start a new sum (prior value and flag treated as 0)
- signal_neg  in  1  with load: accumulate -data_in
- signal_sel  in  SEL_WIDTH  target channel for load
- data_in  in  DATA_WIDTH  operand
- attr_in  in  ATTR_WIDTH  operand attributes; only bit OVERFLOW is used
- signal_oe  in  1  read enable
- signal_oe_sel  in  SEL_WIDTH  channel to read
- data_out  out  DATA_WIDTH  registered read data
- attr_out  out  ATTR_WIDTH  registered read attributes

Behaviour:
- Reset (rst=0, async): all accumulators, sign and overflow flags, stage-1 valid, data_out and attr_out go to 0. Loads in flight are dropped. Release is synchronous to clk.
- Stage 1, the load cycle t: register ext = signal_neg ? -data_in : data_in (mod 2^DATA_WIDTH), plus channel, init, attr_in[OVERFLOW] and neg_ovf. neg_ovf = signal_neg and data_in == most-negative value.
- Stage 2, cycle t+1, when stage-1 valid:
  - a = init ? 0 : acc[ch]
  - s = sext(a) + sext(ext), DATA_WIDTH+1 bits
  - arith_ovf = s[DW] xor s[DW-1], or neg_ovf
  - acc[ch] <= SATURATE and arith_ovf ? (s[DW] ? min : max) : s[DW-1:0]
  - sign[ch] <= s[DW] (true sign of the exact sum)
  - ovf[ch] <= (init ? 0 : ovf[ch]) | attr_ovf | arith_ovf
  - With neg_ovf and SATURATE=1, ext is treated as +max.
- Back-to-back loads to the same channel need no stall: each stage-2 read uses the value written at the preceding edge.
- Load with signal_sel >= CHANNELS: captured but no state changes.
- signal_init/signal_neg are ignored without signal_load.
- Read, 1-cycle latency: at the edge ending cycle r:
  - signal_oe=0: data_out and attr_out <= 0.
  - Otherwise data_out <= acc[oe_sel], attr_out[SIGN] <= sign[oe_sel], attr_out[OVERFLOW] <= ovf[oe_sel], all other attr bits 0.
- Read bypass: if stage 2 writes oe_sel in cycle r, the read returns the newly computed value and flags. Load at t, oe at t+1 therefore shows the new sum at data_out after edge t+1.
- Read with oe_sel >= CHANNELS returns 0.
- Load and read of different channels in the same cycle are independent.

Decomposition:
- Shared package pu_accum_pkg holds:
  - attr index constants SIGN and OVERFLOW
  - a saturation-limit function (max/min for a width)
  - a clog2 helper for SEL_WIDTH
- One natural sub-module: pu_accum_bank_alu, combinational stage-2 adder producing s, arith_ovf and the saturated result. It is instantiated once and shared by all channels.
- The channel register file and flags stay in the top module.

Test Plan (DATA_WIDTH=8, CHANNELS=4):
- Basic sum: load ch0 init 5, then load ch0 neg 3, oe ch0 two cycles later -> data_out 0x02, SIGN=0, OVERFLOW=0.
- Interleaving: one load per cycle, ch1 init 10, ch2 init 0xFC, ch1 +20, ch2 +1 -> ch1=0x1E SIGN=0; ch2=0xFD SIGN=1; ch0 and ch3 unchanged at 0.
- Overflow: ch0 init 100, then +100.
  - SATURATE=0 -> 0xC8, SIGN=0, OVERFLOW=1.
  - SATURATE=1 -> 0x7F, OVERFLOW=1.
  - Later init 1 clears OVERFLOW; load with attr_in[OVERFLOW]=1 sets it again.
- Negating most-negative: ch3 init neg 0x80 -> SATURATE=0: 0x80, OVERFLOW=1; SATURATE=1: 0x7F, OVERFLOW=1.
- Bypass and read edges: load ch2 init 7 at t, oe ch2 at t+1 -> data_out 0x07 after edge t+1. oe low -> 0. oe_sel=5 on CHANNELS=4 -> 0.
- Reset mid-stream: assert rst=0 between stage 1 and stage 2 of a load -> outputs 0 immediately; after release all channels read 0 and the dropped load has no effect.
